// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor sequencer: one shared 1-bit subtract cell, LSB first, borrow chained.
// Optional macro SERIAL_SUB_SAT_EN clamps a negative result to zero (borrow still reported).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for an operand pair (in_ready=1)
// RUN   | stepping one bit per clock through the subtract cell
// DONE  | result valid, held until the consumer takes it
module serial_sub_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
            $error("serial_sub_ctrl: WIDTH must be in 2..32");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   res_sh_q, res_sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               brw_q, brw_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;

    logic               cell_d;
    logic               cell_bout;
    logic [WIDTH-1:0]   res_next;

    // The shared subtract cell.
    always_comb begin
        cell_d    = a_sh_q[0] ^ b_sh_q[0] ^ brw_q;
        cell_bout = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & brw_q);
        res_next  = {cell_d, res_sh_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        cnt_d    = cnt_q;
        brw_d    = brw_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    res_sh_d = '0;
                    cnt_d    = '0;
                    brw_d    = 1'b0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                res_sh_d = res_next;
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                brw_d    = cell_bout;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d  = S_DONE;
                    borrow_d = cell_bout;
`ifdef SERIAL_SUB_SAT_EN
                    diff_d   = cell_bout ? '0 : res_next;
`else
                    diff_d   = res_next;
`endif
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            cnt_q    <= '0;
            brw_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            cnt_q    <= cnt_d;
            brw_q    <= brw_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    // Outputs are register values or plain state decode only.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign diff      = diff_q;
    assign borrow    = borrow_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WIDTH=8): directed edge cases plus random pairs
// against an arithmetic reference; honours SERIAL_SUB_SAT_EN when defined.
module tb_serial_sub_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow;
    logic         busy;

    int n_checks = 0;
    int n_fails  = 0;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic on the operands.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
        int unsigned  full;
        logic [W-1:0] d;
        logic         bo;
        full = (int'(x) - int'(y) + (1 << W)) % (1 << W);
        d    = full[W-1:0];
        bo   = (x < y);
`ifdef SERIAL_SUB_SAT_EN
        if (bo) d = '0;
`endif
        return {bo, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, latency, optional back-pressure, handoff.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input int hold, input bit noise);
        logic [W:0]   r;
        logic [W-1:0] ed;
        logic         eb;
        int           lat;
        r  = ref_sub(ta, tb_v);
        ed = r[W-1:0];
        eb = r[W];
        a = ta;
        b = tb_v;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        check("in_ready_idle", in_ready, 1);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < W + 4) begin
            if (noise) begin
                a = W'($urandom);
                b = W'($urandom);
                in_valid = 1'b1;
            end
            check("in_ready_run", in_ready, 0);
            check("busy_run", busy, 1);
            tick();
            lat++;
        end
        in_valid = 1'b0;
        check("latency", lat, W);
        check("out_valid", out_valid, 1);
        check("diff", diff, ed);
        check("borrow", borrow, eb);
        check("in_ready_done", in_ready, 0);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("bp_out_valid", out_valid, 1);
            check("bp_diff", diff, ed);
            check("bp_borrow", borrow, eb);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("handoff_out_valid", out_valid, 0);
        check("handoff_in_ready", in_ready, 1);
        check("handoff_busy", busy, 0);
        check("idle_diff_kept", diff, ed);
        check("idle_borrow_kept", borrow, eb);
    endtask

    initial begin
        logic [W:0] r;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        #2;
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", in_ready, 1);

        run_op(8'd200, 8'd55, 0, 1'b0);
        run_op(8'd5,   8'd10, 0, 1'b0);
        run_op(8'd0,   8'd0,  0, 1'b0);
        run_op(8'd255, 8'd255, 0, 1'b0);
        run_op(8'd0,   8'd1,  0, 1'b0);
        run_op(8'd255, 8'd0,  0, 1'b0);
        run_op(8'd77,  8'd140, 5, 1'b0);
        run_op(8'd180, 8'd33, 0, 1'b1);

        // Out_ready while idle must not disturb anything.
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        check("idle_out_ready_ov", out_valid, 0);
        check("idle_out_ready_ir", in_ready, 1);

        // Asynchronous reset in the middle of a run, with cnt at 3.
        a = 8'd9;
        b = 8'd200;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("pre_rst_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_diff", diff, 0);
        check("async_rst_borrow", borrow, 0);
        check("async_rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_op(8'd100, 8'd42, 0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            run_op(W'($urandom), W'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        r = ref_sub(8'd3, 8'd4);
        run_op(8'd3, 8'd4, 1, 1'b1);
        check("final_borrow_ref", borrow, r[W]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
